// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 asynchronous serial receiver with a valid/ack holding
// register and a sticky overrun flag.
//
// Parameter T is the bit period in CLK cycles; the start bit is qualified at
// its midpoint and every later bit is sampled one full period after the
// previous sample point, so data bits are taken near their centres.
//
// Optional feature, macro UART_RECEIVER_FERR_EN:
//   defined   - a stop bit sampled low pulses ferr for one cycle, drops the
//               byte and parks the FSM in BREAK until the line returns high.
//   undefined - ferr is tied low and the stop bit value is not checked; the
//               byte is always delivered, and a low line still parks in BREAK.
module uart_receiver #(
  parameter int unsigned T = 2585
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       RX,
  input  logic       ack,
  output logic [7:0] data,
  output logic       valid,
  output logic       overrun,
  output logic       ferr
);

  localparam int unsigned CNT_W = 14;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned DAT_W = 8;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(T - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'((T / 2) - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DAT_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t state;
  state_t state_nx;

  logic             rx_m;
  logic             rx_s;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [DAT_W-1:0] shreg;

  logic half_hit_c;
  logic bit_hit_c;
  logic cnt_clr_c;
  logic idx_clr_c;
  logic sample_c;
  logic done_c;
`ifdef UART_RECEIVER_FERR_EN
  logic ferr_c;
`endif

  // Two-flop synchronizer; idles high so reset does not look like a start bit
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
    end
  end

  // Bit-time boundaries seen by the FSM
  assign half_hit_c = (cnt == HALF_LAST);
  assign bit_hit_c  = (cnt == BIT_LAST);

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (!rx_s) state_nx = S_START;
      end
      S_START: begin
        if (half_hit_c) state_nx = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (bit_hit_c && (idx == IDX_LAST)) state_nx = S_STOP;
      end
      S_STOP: begin
        // A low stop bit means the line is held low: wait it out in BREAK
        if (bit_hit_c) state_nx = rx_s ? S_IDLE : S_BREAK;
      end
      S_BREAK: begin
        if (rx_s) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Per-state control strobes for the counter, shifter and holding register
  always_comb begin
    cnt_clr_c = 1'b0;
    idx_clr_c = 1'b0;
    sample_c  = 1'b0;
    done_c    = 1'b0;
`ifdef UART_RECEIVER_FERR_EN
    ferr_c    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        cnt_clr_c = 1'b1;
      end
      S_START: begin
        cnt_clr_c = half_hit_c;
        idx_clr_c = half_hit_c;
      end
      S_DATA: begin
        cnt_clr_c = bit_hit_c;
        sample_c  = bit_hit_c;
      end
      S_STOP: begin
        cnt_clr_c = bit_hit_c;
`ifdef UART_RECEIVER_FERR_EN
        done_c    = bit_hit_c & rx_s;
        ferr_c    = bit_hit_c & ~rx_s;
`else
        done_c    = bit_hit_c;
`endif
      end
      S_BREAK: begin
        cnt_clr_c = 1'b1;
      end
      default: begin
        cnt_clr_c = 1'b1;
      end
    endcase
  end

  // Bit-time counter: free-runs inside a frame, restarts at each boundary
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (cnt_clr_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Data bit index, restarted when the start bit is accepted
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      idx <= '0;
    end else if (idx_clr_c) begin
      idx <= '0;
    end else if (sample_c) begin
      idx <= idx + IDX_W'(1);
    end
  end

  // LSB-first shift register: new bit enters at the MSB
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shreg <= '0;
    end else if (sample_c) begin
      shreg <= {rx_s, shreg[DAT_W-1:1]};
    end
  end

  // Holding register with valid/ack handshake and sticky overrun
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else if (done_c) begin
      data  <= shreg;
      valid <= 1'b1;
      // An ack in the same cycle consumes the old byte, so no overrun
      if (valid) overrun <= ~ack;
    end else if (ack && valid) begin
      valid   <= 1'b0;
      overrun <= 1'b0;
    end
  end

`ifdef UART_RECEIVER_FERR_EN
  // Registered one-cycle framing error pulse
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ferr <= 1'b0;
    end else begin
      ferr <= ferr_c;
    end
  end
`else
  // Framing errors are not reported in this build
  assign ferr = 1'b0;
`endif

endmodule
